mem_io_bridge: RTL and testbench



---
 rtl/mem_io_pkg.sv | 16 +
 rtl/mem_io_bridge_if.sv | 46 ++++
 rtl/io_addr_decoder.sv | 28 ++
 rtl/mem_io_bridge.sv | 169 ++++++++++++++++
 tb/tb_mem_io_bridge.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants for the memory/IO bridge: FSM encoding, default IO window and idle bus value.
package mem_io_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_IO_WAIT = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

  localparam logic [31:0] IO_BASE_DEFAULT        = 32'hFFFF_FC60;
  localparam int unsigned IO_STRIDE_LOG2_DEFAULT = 4;

  // Value replicated across write_data when no store is in flight.
  localparam logic IDLE_WDATA_BIT = 1'b0;

endpackage

// File: rtl/mem_io_bridge_if.sv
// Execute-stage / memory / peripheral bus bundle seen by the bridge.
interface mem_io_bridge_if
  import mem_io_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned IO_DATA_W      = 16,
  parameter int unsigned N_IO           = 4,
  parameter int unsigned IO_STRIDE_LOG2 = IO_STRIDE_LOG2_DEFAULT
) ();

  logic [ADDR_W-1:0]         caddress;
  logic                      memread;
  logic                      memwrite;
  logic                      ioread;
  logic                      iowrite;
  logic [DATA_W-1:0]         mread_data;
  logic [DATA_W-1:0]         wdata;
  logic [N_IO*IO_DATA_W-1:0] io_rdata;
  logic [N_IO-1:0]           io_ready;

  logic [ADDR_W-1:0]         address;
  logic [DATA_W-1:0]         write_data;
  logic [DATA_W-1:0]         rdata;
  logic [N_IO-1:0]           io_cs;
  logic                      io_rd;
  logic                      io_wr;
  logic [IO_STRIDE_LOG2-1:0] io_offset;
  logic [IO_DATA_W-1:0]      io_wdata;
  logic                      stall;
  logic                      bus_err;
  logic [ADDR_W-1:0]         err_addr;

  modport master (
    output caddress, memread, memwrite, ioread, iowrite, mread_data, wdata, io_rdata, io_ready,
    input  address, write_data, rdata, io_cs, io_rd, io_wr, io_offset, io_wdata, stall,
           bus_err, err_addr
  );

  modport slave (
    input  caddress, memread, memwrite, ioread, iowrite, mread_data, wdata, io_rdata, io_ready,
    output address, write_data, rdata, io_cs, io_rd, io_wr, io_offset, io_wdata, stall,
           bus_err, err_addr
  );

endinterface

// File: rtl/io_addr_decoder.sv
// Maps a byte address onto one of N_IO equally sized peripheral windows.
module io_addr_decoder
  import mem_io_pkg::*;
#(
  parameter int unsigned      ADDR_W         = 32,
  parameter int unsigned      N_IO           = 4,
  parameter logic [ADDR_W-1:0] IO_BASE       = IO_BASE_DEFAULT,
  parameter int unsigned      IO_STRIDE_LOG2 = IO_STRIDE_LOG2_DEFAULT,
  parameter int unsigned      CH_W           = 2
) (
  input  logic [ADDR_W-1:0]         caddress,
  output logic                      hit,
  output logic [CH_W-1:0]           ch,
  output logic [IO_STRIDE_LOG2-1:0] io_offset,
  output logic [N_IO-1:0]           cs
);

  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] idx;

  assign diff      = caddress - IO_BASE;
  assign idx       = diff >> IO_STRIDE_LOG2;
  assign hit       = (caddress >= IO_BASE) && (idx < ADDR_W'(N_IO));
  assign ch        = idx[CH_W-1:0];
  assign io_offset = caddress[IO_STRIDE_LOG2-1:0];
  assign cs        = hit ? (N_IO'(1) << ch) : '0;

endmodule

// File: rtl/mem_io_bridge.sv
// Execute-stage bridge: single-cycle memory pass-through plus a stalling, timed-out IO channel
// access path with a sticky first-error record.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       IO_DATA_W      = 16,
  parameter int unsigned       N_IO           = 4,
  parameter logic [ADDR_W-1:0] IO_BASE        = IO_BASE_DEFAULT,
  parameter int unsigned       IO_STRIDE_LOG2 = IO_STRIDE_LOG2_DEFAULT,
  parameter int unsigned       TIMEOUT_CYC    = 255
) (
  input logic            clock,
  input logic            reset_n,
  mem_io_bridge_if.slave bus
);

  localparam int unsigned CH_W  = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic                    dec_hit;
  logic [CH_W-1:0]         dec_ch;
  logic [N_IO-1:0]         dec_cs;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       rd_latch_q, rd_latch_d;
  logic                    bus_err_q, bus_err_d;
  logic [ADDR_W-1:0]       err_addr_q, err_addr_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [N_IO-1:0]         cs_q, cs_d;
  logic                    rd_q, rd_d, wr_q, wr_d;

  logic [N_IO-1:0]         io_cs;
  logic                    io_rd, io_wr, stall, io_sel;
  logic [IO_DATA_W-1:0]    slice_live, slice_held;

  io_addr_decoder #(
    .ADDR_W        (ADDR_W),
    .N_IO          (N_IO),
    .IO_BASE       (IO_BASE),
    .IO_STRIDE_LOG2(IO_STRIDE_LOG2),
    .CH_W          (CH_W)
  ) u_dec (
    .caddress (bus.caddress),
    .hit      (dec_hit),
    .ch       (dec_ch),
    .io_offset(bus.io_offset),
    .cs       (dec_cs)
  );

  assign io_sel     = bus.ioread | bus.iowrite;
  assign slice_live = bus.io_rdata[int'(dec_ch) * IO_DATA_W +: IO_DATA_W];
  assign slice_held = bus.io_rdata[int'(ch_q) * IO_DATA_W +: IO_DATA_W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_latch_d = rd_latch_q;
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    ch_d       = ch_q;
    cs_d       = cs_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    io_cs      = '0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (io_sel) begin
          stall = 1'b1;
          cnt_d = '0;
          if (dec_hit) begin
            io_cs = dec_cs;
            io_rd = bus.ioread;
            io_wr = bus.iowrite;
            ch_d  = dec_ch;
            cs_d  = dec_cs;
            rd_d  = bus.ioread;
            wr_d  = bus.iowrite;
            // A peripheral that answers in the select cycle skips the wait state entirely.
            if (bus.io_ready[dec_ch]) begin
              rd_latch_d = bus.ioread ? DATA_W'(slice_live) : '0;
              state_d    = ST_DONE;
            end else begin
              state_d = ST_IO_WAIT;
            end
          end else begin
            rd_latch_d = '0;
            if (!bus_err_q) begin
              bus_err_d  = 1'b1;
              err_addr_d = bus.caddress;
            end
            state_d = ST_DONE;
          end
        end
      end
      ST_IO_WAIT: begin
        stall = 1'b1;
        io_cs = cs_q;
        io_rd = rd_q;
        io_wr = wr_q;
        if (bus.io_ready[ch_q]) begin
          rd_latch_d = rd_q ? DATA_W'(slice_held) : '0;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rd_latch_d = '0;
          if (!bus_err_q) begin
            bus_err_d  = 1'b1;
            err_addr_d = bus.caddress;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_latch_q <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
      ch_q       <= '0;
      cs_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_latch_q <= rd_latch_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
      ch_q       <= ch_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Strobes are masked during reset so a held IO control cannot reach a peripheral.
  assign bus.io_cs      = reset_n ? io_cs : '0;
  assign bus.io_rd      = reset_n & io_rd;
  assign bus.io_wr      = reset_n & io_wr;
  assign bus.stall      = reset_n & stall;
  assign bus.address    = bus.caddress;
  assign bus.io_wdata   = bus.wdata[IO_DATA_W-1:0];
  assign bus.bus_err    = bus_err_q;
  assign bus.err_addr   = err_addr_q;
  assign bus.write_data = (bus.memwrite | bus.iowrite) ? bus.wdata : {DATA_W{IDLE_WDATA_BIT}};

  always_comb begin
    bus.rdata = '0;
    if (bus.memread) begin
      bus.rdata = bus.mread_data;
    end else if (bus.ioread && (state_q == ST_DONE)) begin
      bus.rdata = rd_latch_q;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench: the driver predicts each access from the address map and handshake rules,
// an independent monitor checks strobes while stalled and results on the completing cycle.
module tb_mem_io_bridge;

  localparam logic [31:0] IO_BASE = 32'hFFFF_FC60;
  localparam int          TMO     = 8;
  localparam int          N_IO    = 4;

  typedef struct {
    logic [31:0] rdata;
    int          stall;
    logic        err;
    logic [31:0] eaddr;
    logic [3:0]  cs;
    logic        rd;
    logic        wr;
    logic [3:0]  off;
    logic [15:0] iw;
    logic [31:0] wrd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  bit   mon_en;
  logic        m_err;
  logic [31:0] m_eaddr;
  exp_t q[$];

  mem_io_bridge_if #(
    .ADDR_W(32), .DATA_W(32), .IO_DATA_W(16), .N_IO(N_IO), .IO_STRIDE_LOG2(4)
  ) bus ();

  mem_io_bridge #(
    .ADDR_W(32), .DATA_W(32), .IO_DATA_W(16), .N_IO(N_IO), .IO_BASE(IO_BASE),
    .IO_STRIDE_LOG2(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_bus();
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.ioread   = 1'b0;
    bus.iowrite  = 1'b0;
    bus.io_ready = '0;
  endtask

  // kind: 0 memread, 1 memwrite, 2 ioread, 3 iowrite; n = cycle of io_ready, 0 = select cycle
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] md, input int n, input logic [15:0] rdv);
    exp_t        e;
    logic        hit, is_io, fail_io;
    int          ch;
    logic [31:0] rnd;
    logic [3:0]  rdy;
    hit   = (addr >= IO_BASE) && (((addr - IO_BASE) >> 4) < N_IO);
    ch    = hit ? int'((addr - IO_BASE) >> 4) : 0;
    is_io = (kind >= 2);
    if (!is_io)        e.stall = 0;
    else if (!hit)     e.stall = 1;
    else if (n <= TMO) e.stall = n + 1;
    else               e.stall = TMO + 1;
    fail_io = is_io && (!hit || n > TMO);
    if (fail_io && !m_err) begin
      m_err   = 1'b1;
      m_eaddr = addr;
    end
    e.err   = m_err;
    e.eaddr = m_eaddr;
    if (kind == 0)                           e.rdata = md;
    else if (kind == 2 && hit && n <= TMO)   e.rdata = {16'h0, rdv};
    else                                     e.rdata = 32'h0;
    e.cs  = (hit && is_io) ? (4'b0001 << ch) : 4'b0000;
    e.rd  = (kind == 2) && hit;
    e.wr  = (kind == 3) && hit;
    e.off = addr[3:0];
    e.iw  = wd[15:0];
    e.wrd = (kind == 1 || kind == 3) ? wd : 32'h0;
    q.push_back(e);
    bus.caddress   = addr;
    bus.wdata      = wd;
    bus.mread_data = md;
    bus.memread    = (kind == 0);
    bus.memwrite   = (kind == 1);
    bus.ioread     = (kind == 2);
    bus.iowrite    = (kind == 3);
    for (int c = 0; c <= e.stall; c++) begin
      rnd = $urandom;
      rdy = rnd[3:0];
      if (hit) rdy[ch] = (c == n);
      bus.io_ready = rdy;
      bus.io_rdata = {$urandom, $urandom};
      if (hit) bus.io_rdata[ch*16 +: 16] = rdv;
      @(posedge clk); #1;
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  // Monitor: strobes during stall, results on the first non-stalled cycle of each access.
  initial begin : monitor
    int   scnt;
    exp_t e;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en && (bus.memread | bus.memwrite | bus.ioread | bus.iowrite)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got an access expected none at %0t", $time);
        end else begin
          e = q[0];
          if (bus.stall) begin
            scnt++;
            chk("io_cs", 64'(bus.io_cs), 64'(e.cs));
            chk("io_rd", 64'(bus.io_rd), 64'(e.rd));
            chk("io_wr", 64'(bus.io_wr), 64'(e.wr));
            if (scnt == 1) begin
              chk("io_offset", 64'(bus.io_offset), 64'(e.off));
              chk("io_wdata", 64'(bus.io_wdata), 64'(e.iw));
            end
          end else begin
            chk("stall_cycles", 64'(scnt), 64'(e.stall));
            chk("rdata", 64'(bus.rdata), 64'(e.rdata));
            chk("bus_err", 64'(bus.bus_err), 64'(e.err));
            chk("err_addr", 64'(bus.err_addr), 64'(e.eaddr));
            chk("write_data", 64'(bus.write_data), 64'(e.wrd));
            chk("done_io_cs", 64'(bus.io_cs), 64'h0);
            chk("done_strobes", 64'({bus.io_rd, bus.io_wr}), 64'h0);
            void'(q.pop_front());
            scnt = 0;
          end
        end
      end
    end
  end

  initial begin : stim
    int          kind, n, sel;
    logic [31:0] addr;
    errors  = 0;
    checks  = 0;
    mon_en  = 1'b0;
    m_err   = 1'b0;
    m_eaddr = 32'h0;
    idle_bus();
    rst_n          = 1'b0;
    bus.iowrite    = 1'b1;
    bus.caddress   = IO_BASE;
    bus.wdata      = 32'h0;
    bus.mread_data = 32'h0;
    bus.io_rdata   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_io_cs", 64'(bus.io_cs), 64'h0);
    chk("rst_strobes", 64'({bus.io_rd, bus.io_wr}), 64'h0);
    chk("rst_stall", 64'(bus.stall), 64'h0);
    chk("rst_bus_err", 64'(bus.bus_err), 64'h0);
    chk("rst_err_addr", 64'(bus.err_addr), 64'h0);
    chk("rst_rdata", 64'(bus.rdata), 64'h0);
    idle_bus();
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    access(0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 16'h0);
    access(2, 32'hFFFF_FC70, 32'h0, 32'h0, 2, 16'hBEEF);
    access(3, 32'hFFFF_FC64, 32'hCAFE_00AA, 32'h0, 0, 16'h0);
    access(2, 32'hFFFF_FC70, 32'h0, 32'h0, 99, 16'h1111);
    access(3, 32'hFFFF_FCF0, 32'h5555_AAAA, 32'h0, 0, 16'h0);

    // Reset in the middle of a wait: strobes must drop and the error record must clear.
    mon_en       = 1'b0;
    bus.caddress = 32'hFFFF_FC70;
    bus.ioread   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_stall", 64'(bus.stall), 64'h1);
    chk("mid_io_cs", 64'(bus.io_cs), 64'h2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_stall", 64'(bus.stall), 64'h0);
    chk("rst_mid_io_cs", 64'(bus.io_cs), 64'h0);
    chk("rst_mid_io_rd", 64'(bus.io_rd), 64'h0);
    @(posedge clk); #1;
    idle_bus();
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_bus_err", 64'(bus.bus_err), 64'h0);
    @(posedge clk); #1;
    m_err   = 1'b0;
    m_eaddr = 32'h0;
    mon_en  = 1'b1;
    access(2, 32'hFFFF_FC70, 32'h0, 32'h0, 1, 16'h7A5C);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      n    = $urandom_range(0, 10);
      sel  = $urandom_range(0, 3);
      if (kind < 2)      addr = $urandom;
      else if (sel < 2)  addr = IO_BASE + 32'($urandom_range(0, N_IO - 1) * 16)
                                + 32'($urandom_range(0, 15));
      else if (sel == 2) addr = IO_BASE + 32'h40 + 32'($urandom_range(0, 900));
      else               addr = 32'($urandom_range(0, 32'h7FFF_FFFF));
      access(kind, addr, $urandom, $urandom, n, 16'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
